// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage sequencer between the PC and a fixed-latency instruction BRAM.
// One word read is issued per cycle. Each read is tracked through a
// MEM_LATENCY-deep {valid,pc} shift register, so the returning word can be
// paired with its PC. The pair is then written into a small FIFO that feeds
// the decoder over a valid/ready handshake. A redirect kills every in-flight
// and buffered fetch and restarts fetch at the new target.
//
// Issue is credit based. A read is only issued when the buffered words plus
// the in-flight words, less this cycle's pop, leave a free FIFO slot. Because
// of this, a returning word always finds space and the BRAM never needs a
// stall.
//
// Parameters
//   PC_W         PC width in bits; BRAM word address is pc[PC_W-1:2]
//   INSTR_W      instruction word width
//   MEM_LATENCY  BRAM read latency in cycles (1..3)
//   FIFO_DEPTH   output buffer entries (>= MEM_LATENCY+1)
//   RESET_PC     first fetch PC after reset (4-byte aligned)
//
// Ports
//   clk               clock, all logic on posedge
//   rst               synchronous active-high reset
//   i_redirect_valid  flush everything and restart at i_redirect_pc
//   i_redirect_pc     redirect target; bits [1:0] ignored
//   o_imem_en         BRAM read enable, high only on issue
//   o_imem_addr       BRAM word address (zero when not issuing)
//   i_imem_rdata      BRAM data, valid MEM_LATENCY cycles after issue
//   o_valid           head instruction available to decode
//   o_pc              PC of head instruction
//   o_instr           head instruction word
//   i_ready           decoder accepts head; pop = o_valid & i_ready
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int              PC_W        = 9,
    parameter int              INSTR_W     = 32,
    parameter int              MEM_LATENCY = 1,
    parameter int              FIFO_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_imem_en,
    output logic [PC_W-3:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    input  logic               i_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = 2;              // at most 3 reads in flight
    localparam int CRD_W = CNT_W + INF_W;  // holds count + inflight
    localparam int LAST  = MEM_LATENCY - 1;

    // Fetch PC and read-tracking shift register
    logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [MEM_LATENCY-1:0] stage_valid_q, stage_valid_d;
    logic [PC_W-1:0]        stage_pc_q [MEM_LATENCY];
    logic [PC_W-1:0]        stage_pc_d [MEM_LATENCY];

    // Output FIFO
    logic [PC_W-1:0]    fifo_pc_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic             issue;
    logic             push;
    logic             pop;
    logic             head_live;
    logic [INF_W-1:0] inflight;
    logic [CRD_W-1:0] credit_used;

    // Pointers wrap modulo FIFO_DEPTH, so the depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        r = p + PTR_W'(1);
        if (p == PTR_W'(FIFO_DEPTH - 1)) r = '0;
        return r;
    endfunction

    // NOTE: every signal written here is given a default value first. With no
    // path left unassigned, no latch is inferred.
    always_comb begin
        // Handshake and credit accounting
        inflight    = INF_W'($countones(stage_valid_q));
        head_live   = !rst && (count_q != '0);
        o_valid     = head_live && !i_redirect_valid;
        pop         = o_valid && i_ready;
        push        = stage_valid_q[LAST] && !i_redirect_valid;
        credit_used = CRD_W'(count_q) + CRD_W'(inflight) - CRD_W'(pop);
        issue       = !rst && !i_redirect_valid && (credit_used < CRD_W'(FIFO_DEPTH));

        o_imem_en   = issue;
        o_imem_addr = issue ? fetch_pc_q[PC_W-1:2] : '0;
        o_pc        = head_live ? fifo_pc_q[rd_ptr_q]    : '0;
        o_instr     = head_live ? fifo_instr_q[rd_ptr_q] : '0;

        // Fetch PC. The redirect target is forced to word alignment.
        fetch_pc_d = fetch_pc_q;
        if (i_redirect_valid) begin
            fetch_pc_d = i_redirect_pc & ~PC_W'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
        end

        // Read tracking. A redirect drops every in-flight read. Stage 0 is
        // already clear then, because issue is low during a redirect.
        stage_valid_d    = '0;
        stage_valid_d[0] = issue;
        stage_pc_d[0]    = fetch_pc_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1] && !i_redirect_valid;
            stage_pc_d[i]    = stage_pc_q[i-1];
        end

        // FIFO bookkeeping. A push and a pop in the same cycle leave count unchanged.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // update together on the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            stage_valid_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the data arrays are not reset. Their contents are only observed
    // through a valid bit or a nonzero count, and both of those are reset.
    always_ff @(posedge clk) begin
        stage_pc_q <= stage_pc_d;
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= stage_pc_q[LAST];
            fifo_instr_q[wr_ptr_q] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. It drives three instances from one clock:
//   dut 0: MEM_LATENCY=1, RESET_PC=0x000
//   dut 1: MEM_LATENCY=1, RESET_PC=0x1F8  (PC wrap)
//   dut 2: MEM_LATENCY=2, RESET_PC=0x000
// BRAM word k holds 32'h1000_0000 + k. Cycle 0 of a run is the first cycle
// with rst low. Inputs change 1 time unit after posedge, and outputs are
// sampled on negedge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst      [3];
    logic        redir_v  [3];
    logic [8:0]  redir_pc [3];
    logic        ready    [3];
    logic        imem_en  [3];
    logic [6:0]  imem_addr[3];
    logic [31:0] rdata    [3];
    logic        o_valid  [3];
    logic [8:0]  o_pc     [3];
    logic [31:0] o_instr  [3];

    // BRAM models: p1 has 1-cycle latency, p2 adds one more stage.
    logic [31:0] p1 [3];
    logic [31:0] p2 [3];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            p1[d] <= 32'h1000_0000 + {25'b0, imem_addr[d]};
            p2[d] <= p1[d];
        end
    end

    assign rdata[0] = p1[0];
    assign rdata[1] = p1[1];
    assign rdata[2] = p2[2];

    fetch_ctrl #(.MEM_LATENCY(1), .RESET_PC(9'h000)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .i_redirect_valid(redir_v[0]), .i_redirect_pc(redir_pc[0]),
        .o_imem_en(imem_en[0]), .o_imem_addr(imem_addr[0]), .i_imem_rdata(rdata[0]),
        .o_valid(o_valid[0]), .o_pc(o_pc[0]), .o_instr(o_instr[0]), .i_ready(ready[0])
    );

    fetch_ctrl #(.MEM_LATENCY(1), .RESET_PC(9'h1F8)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .i_redirect_valid(redir_v[1]), .i_redirect_pc(redir_pc[1]),
        .o_imem_en(imem_en[1]), .o_imem_addr(imem_addr[1]), .i_imem_rdata(rdata[1]),
        .o_valid(o_valid[1]), .o_pc(o_pc[1]), .o_instr(o_instr[1]), .i_ready(ready[1])
    );

    fetch_ctrl #(.MEM_LATENCY(2), .RESET_PC(9'h000)) u_dut2 (
        .clk(clk), .rst(rst[2]),
        .i_redirect_valid(redir_v[2]), .i_redirect_pc(redir_pc[2]),
        .o_imem_en(imem_en[2]), .o_imem_addr(imem_addr[2]), .i_imem_rdata(rdata[2]),
        .o_valid(o_valid[2]), .o_pc(o_pc[2]), .o_instr(o_instr[2]), .i_ready(ready[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int d, input logic v,
                           input logic [8:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, 64'(o_valid[d]), 64'(v));
        if (v) begin
            check({tag, "_pc"}, 64'(o_pc[d]), 64'(pc));
            check({tag, "_instr"}, 64'(o_instr[d]), 64'(ins));
        end
    endtask

    task automatic chk_issue(input string tag, input int d, input logic en, input logic [6:0] addr);
        check({tag, "_en"}, 64'(imem_en[d]), 64'(en));
        if (en) check({tag, "_addr"}, 64'(imem_addr[d]), 64'(addr));
    endtask

    task automatic chk_reset(input string tag, input int d);
        check({tag, "_valid"}, 64'(o_valid[d]), 64'd0);
        check({tag, "_en"},    64'(imem_en[d]), 64'd0);
        check({tag, "_addr"},  64'(imem_addr[d]), 64'd0);
        check({tag, "_pc"},    64'(o_pc[d]), 64'd0);
        check({tag, "_instr"}, 64'(o_instr[d]), 64'd0);
    endtask

    logic [8:0]  wrap_pc    [4];
    logic [31:0] wrap_instr [4];

    initial begin
        wrap_pc    = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
        wrap_instr = '{32'h1000_007E, 32'h1000_007F, 32'h1000_0000, 32'h1000_0001};
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; redir_v[d] = 1'b0; redir_pc[d] = '0; ready[d] = 1'b0;
        end
        tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_reset($sformatf("rst_d%0d", d), d);
        tick();

        // ---- Streaming with ready=1, latency 1 ----
        ready[0] = 1'b1; rst[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk_issue($sformatf("s1_c%0d", c), 0, 1'b1, 7'(c));
            if (c >= 2) chk_out($sformatf("s1_c%0d", c), 0, 1'b1, 9'(4 * (c - 2)), 32'h1000_0000 + 32'(c - 2));
            else        chk_out($sformatf("s1_c%0d", c), 0, 1'b0, 9'h0, 32'h0);
            tick();
        end
        // Redirect while a head is valid and ready=1, then a second redirect
        // on the next cycle. The last target wins and the old head is dropped.
        redir_v[0] = 1'b1; redir_pc[0] = 9'h080;
        @(negedge clk);
        chk_out("rd_c8", 0, 1'b0, 9'h0, 32'h0);
        chk_issue("rd_c8", 0, 1'b0, 7'h0);
        tick();
        redir_pc[0] = 9'h102;
        @(negedge clk);
        chk_out("rd_c9", 0, 1'b0, 9'h0, 32'h0);
        chk_issue("rd_c9", 0, 1'b0, 7'h0);
        tick();
        redir_v[0] = 1'b0;
        @(negedge clk);
        chk_issue("rd_c10", 0, 1'b1, 7'h40);
        chk_out("rd_c10", 0, 1'b0, 9'h0, 32'h0);
        tick();
        @(negedge clk);
        chk_issue("rd_c11", 0, 1'b1, 7'h41);
        chk_out("rd_c11", 0, 1'b0, 9'h0, 32'h0);
        tick();
        @(negedge clk);
        chk_out("rd_c12", 0, 1'b1, 9'h100, 32'h1000_0040);
        tick();
        @(negedge clk);
        chk_out("rd_c13", 0, 1'b1, 9'h104, 32'h1000_0041);
        tick();

        // ---- Stall: ready=0 through cycle 11, then ready=1 ----
        rst[0] = 1'b1; ready[0] = 1'b0;
        tick();
        rst[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk_issue($sformatf("st_c%0d", c), 0, c < 4, 7'(c));
            chk_out($sformatf("st_c%0d", c), 0, c >= 2, 9'h000, 32'h1000_0000);
            tick();
        end
        ready[0] = 1'b1;
        for (int c = 12; c < 18; c++) begin
            @(negedge clk);
            chk_out($sformatf("st_c%0d", c), 0, 1'b1, 9'(4 * (c - 12)), 32'h1000_0000 + 32'(c - 12));
            tick();
        end

        // ---- Redirect with 3 buffered + 1 in flight, then reset when full ----
        rst[0] = 1'b1; ready[0] = 1'b0;
        tick();
        rst[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_issue($sformatf("fl_c%0d", c), 0, 1'b1, 7'(c));
            tick();
        end
        redir_v[0] = 1'b1; redir_pc[0] = 9'h041;
        @(negedge clk);
        chk_out("fl_c4", 0, 1'b0, 9'h0, 32'h0);
        chk_issue("fl_c4", 0, 1'b0, 7'h0);
        tick();
        redir_v[0] = 1'b0;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            chk_issue($sformatf("fl_c%0d", c), 0, c < 9, 7'(16 + c - 5));
            chk_out($sformatf("fl_c%0d", c), 0, c >= 7, 9'h040, 32'h1000_0010);
            tick();
        end
        rst[0] = 1'b1;
        @(negedge clk);
        chk_reset("full_rst", 0);
        tick();
        rst[0] = 1'b0; ready[0] = 1'b1;
        @(negedge clk);
        chk_issue("prst_c0", 0, 1'b1, 7'h0);
        chk_out("prst_c0", 0, 1'b0, 9'h0, 32'h0);
        tick();
        @(negedge clk);
        chk_issue("prst_c1", 0, 1'b1, 7'h1);
        chk_out("prst_c1", 0, 1'b0, 9'h0, 32'h0);
        tick();
        @(negedge clk);
        chk_out("prst_c2", 0, 1'b1, 9'h000, 32'h1000_0000);
        tick();
        @(negedge clk);
        chk_out("prst_c3", 0, 1'b1, 9'h004, 32'h1000_0001);
        tick();

        // ---- PC wrap from RESET_PC=0x1F8 ----
        ready[1] = 1'b1; rst[1] = 1'b0;
        @(negedge clk);
        chk_issue("wr_c0", 1, 1'b1, 7'h7E);
        tick();
        @(negedge clk);
        chk_issue("wr_c1", 1, 1'b1, 7'h7F);
        tick();
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            chk_out($sformatf("wr_c%0d", c), 1, 1'b1, wrap_pc[c-2], wrap_instr[c-2]);
            tick();
        end

        // ---- Latency 2: streaming ----
        ready[2] = 1'b1; rst[2] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk_issue($sformatf("l2_c%0d", c), 2, 1'b1, 7'(c));
            if (c >= 3) chk_out($sformatf("l2_c%0d", c), 2, 1'b1, 9'(4 * (c - 3)), 32'h1000_0000 + 32'(c - 3));
            else        chk_out($sformatf("l2_c%0d", c), 2, 1'b0, 9'h0, 32'h0);
            tick();
        end

        // ---- Latency 2: stall, then redirect with 3 buffered + 1 in flight ----
        rst[2] = 1'b1; ready[2] = 1'b0;
        tick();
        rst[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_issue($sformatf("l2s_c%0d", c), 2, c < 4, 7'(c));
            chk_out($sformatf("l2s_c%0d", c), 2, c >= 3, 9'h000, 32'h1000_0000);
            tick();
        end
        redir_v[2] = 1'b1; redir_pc[2] = 9'h041;
        @(negedge clk);
        chk_out("l2s_c5", 2, 1'b0, 9'h0, 32'h0);
        chk_issue("l2s_c5", 2, 1'b0, 7'h0);
        tick();
        redir_v[2] = 1'b0; ready[2] = 1'b1;
        for (int c = 6; c < 9; c++) begin
            @(negedge clk);
            chk_out($sformatf("l2s_c%0d", c), 2, 1'b0, 9'h0, 32'h0);
            if (c < 8) chk_issue($sformatf("l2s_c%0d", c), 2, 1'b1, 7'(16 + c - 6));
            tick();
        end
        @(negedge clk);
        chk_out("l2s_c9", 2, 1'b1, 9'h040, 32'h1000_0010);
        tick();
        @(negedge clk);
        chk_out("l2s_c10", 2, 1'b1, 9'h044, 32'h1000_0011);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
